// File: rtl/esm_issue_scheduler.sv
// ESM issue scheduler: age-ordered collapsing instruction buffer that picks
// the oldest hazard-free entry each cycle, issues it over valid/ready and
// compacts the remaining entries toward position 0.
module esm_issue_scheduler #(
  parameter int BS     = 8,
  parameter int REGNUM = 16,
  parameter int TAGW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TAGW-1:0]           in_tag,
  input  logic                      in_regwrite,
  input  logic                      in_alusrc,
  input  logic [$clog2(REGNUM)-1:0] in_rd,
  input  logic [$clog2(REGNUM)-1:0] in_rs1,
  input  logic [$clog2(REGNUM)-1:0] in_rs2,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [TAGW-1:0]           iss_tag,
  output logic [$clog2(BS)-1:0]     iss_pos,
  output logic [$clog2(BS):0]       count,
  output logic                      empty,
  output logic                      full
);

  localparam int PW = $clog2(BS);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] BS_C = CW'(BS);

  logic [BS-1:0]     valid_q, valid_d;
  logic [TAGW-1:0]   tag_q [BS];
  logic [TAGW-1:0]   tag_d [BS];
  logic [REGNUM-1:0] rd_q  [BS];
  logic [REGNUM-1:0] rd_d  [BS];
  logic [REGNUM-1:0] rs_q  [BS];
  logic [REGNUM-1:0] rs_d  [BS];
  logic [CW-1:0]     count_q, count_d;

  logic [REGNUM-1:0] new_rd, new_rs;
  logic [REGNUM-1:0] older_rd, older_rs;
  logic [BS-1:0]     haz;
  logic              sel_found;
  logic [PW-1:0]     sel_pos;
  logic              push_fire, iss_fire;
  logic [CW-1:0]     wpos;

  // One-hot register masks for the incoming instruction; x0 never appears
  always_comb begin
    new_rd = '0;
    new_rs = '0;
    if (in_regwrite && (in_rd != '0)) new_rd[in_rd] = 1'b1;
    if (in_rs1 != '0) new_rs[in_rs1] = 1'b1;
    if (!in_alusrc && (in_rs2 != '0)) new_rs[in_rs2] = 1'b1;
  end

  // Hazard check against the union of all older resident entries; pick lowest clean one
  always_comb begin
    older_rd  = '0;
    older_rs  = '0;
    haz       = '0;
    sel_found = 1'b0;
    sel_pos   = '0;
    for (int j = 0; j < BS; j++) begin
      haz[j] = |((older_rd & rs_q[j]) | (older_rs & rd_q[j]) | (older_rd & rd_q[j]));
      if (valid_q[j] && !haz[j] && !sel_found) begin
        sel_found = 1'b1;
        sel_pos   = PW'(j);
      end
      if (valid_q[j]) begin
        older_rd = older_rd | rd_q[j];
        older_rs = older_rs | rs_q[j];
      end
    end
  end

  // Handshake outputs; flush and reset mask both sides so nothing completes
  always_comb begin
    in_ready  = (count_q < BS_C) && !flush && rst;
    iss_valid = sel_found && !flush && rst;
    iss_tag   = sel_found ? tag_q[sel_pos] : '0;
    iss_pos   = sel_pos;
    count     = count_q;
    empty     = (count_q == '0);
    full      = (count_q == BS_C);
    push_fire = in_valid && in_ready;
    iss_fire  = iss_valid && iss_ready;
  end

  // Next buffer contents: collapse over the issued slot, then append at the compacted tail
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < BS; k++) begin
      tag_d[k] = tag_q[k];
      rd_d[k]  = rd_q[k];
      rs_d[k]  = rs_q[k];
    end
    if (iss_fire) begin
      for (int k = 0; k < BS - 1; k++) begin
        if (PW'(k) >= sel_pos) begin
          valid_d[k] = valid_q[k+1];
          tag_d[k]   = tag_q[k+1];
          rd_d[k]    = rd_q[k+1];
          rs_d[k]    = rs_q[k+1];
        end
      end
      valid_d[BS-1] = 1'b0;
      tag_d[BS-1]   = '0;
      rd_d[BS-1]    = '0;
      rs_d[BS-1]    = '0;
    end
    wpos = iss_fire ? (count_q - CW'(1)) : count_q;
    if (push_fire) begin
      for (int k = 0; k < BS; k++) begin
        if (CW'(k) == wpos) begin
          valid_d[k] = 1'b1;
          tag_d[k]   = in_tag;
          rd_d[k]    = new_rd;
          rs_d[k]    = new_rs;
        end
      end
    end
    count_d = count_q + CW'(push_fire) - CW'(iss_fire);
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // State register; synchronous active-low reset discards the whole buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < BS; k++) begin
        tag_q[k] <= '0;
        rd_q[k]  <= '0;
        rs_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < BS; k++) begin
        tag_q[k] <= tag_d[k];
        rd_q[k]  <= rd_d[k];
        rs_q[k]  <= rs_d[k];
      end
    end
  end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Directed bench for esm_issue_scheduler: reset, ordered issue, hazard mixes,
// x0/immediate handling, full/simultaneous push+issue, flush and mid-run reset.
module tb_esm_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready;
  logic [7:0] in_tag;
  logic       in_regwrite, in_alusrc;
  logic [3:0] in_rd, in_rs1, in_rs2;
  logic       iss_valid, iss_ready;
  logic [7:0] iss_tag;
  logic [2:0] iss_pos;
  logic [3:0] count;
  logic       empty, full;

  int n_cmp = 0;
  int n_err = 0;

  esm_issue_scheduler #(.BS(8), .REGNUM(16), .TAGW(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_regwrite(in_regwrite), .in_alusrc(in_alusrc),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag), .iss_pos(iss_pos),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] t, input logic rw, input logic as,
                      input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2);
    in_valid = 1'b1; in_tag = t; in_regwrite = rw; in_alusrc = as;
    in_rd = rd; in_rs1 = r1; in_rs2 = r2;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_tags [7];
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b0;
    in_tag = '0; in_regwrite = 1'b0; in_alusrc = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0;

    // Reset then idle
    tick();
    chk("rst_in_ready_low", in_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_tag", iss_tag, 0);
    chk("rst_iss_pos", iss_pos, 0);
    chk("rst_in_ready_high", in_ready, 1);

    // Independent pair, issued in age order
    push(8'hA1, 1, 0, 4'd1, 4'd2, 4'd3);
    push(8'hB2, 1, 0, 4'd4, 4'd5, 4'd6);
    chk("pair_count", count, 2);
    chk("pair_iss_valid", iss_valid, 1);
    chk("pair_pos", iss_pos, 0);
    chk("pair_tagA", iss_tag, 8'hA1);
    iss_ready = 1'b1;
    tick();
    chk("pair_count1", count, 1);
    chk("pair_tagB", iss_tag, 8'hB2);
    tick();
    chk("pair_count0", count, 0);
    chk("pair_empty", empty, 1);
    chk("pair_iss_valid0", iss_valid, 0);
    iss_ready = 1'b0;

    // RAW chain: B reads A's rd; order must hold and B follows A
    push(8'h11, 1, 0, 4'd1, 4'd2, 4'd3);
    push(8'h12, 1, 0, 4'd5, 4'd1, 4'd0);
    push(8'h13, 1, 0, 4'd6, 4'd7, 4'd8);
    chk("raw_count", count, 3);
    chk("raw_tagA", iss_tag, 8'h11);
    chk("raw_posA", iss_pos, 0);
    tick();
    chk("raw_stall_tag", iss_tag, 8'h11);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    chk("raw_tagB", iss_tag, 8'h12);
    chk("raw_posB", iss_pos, 0);
    chk("raw_count2", count, 2);
    iss_ready = 1'b1;
    tick();
    chk("raw_tagC", iss_tag, 8'h13);
    tick();
    iss_ready = 1'b0;
    chk("raw_empty", empty, 1);

    // WAR then WAW behind A: A still issues first, then the dependents
    push(8'h14, 1, 0, 4'd1, 4'd2, 4'd3);
    push(8'h15, 1, 0, 4'd2, 4'd9, 4'd10);
    push(8'h16, 1, 0, 4'd1, 4'd11, 4'd12);
    chk("hz_tag0", iss_tag, 8'h14);
    iss_ready = 1'b1;
    tick();
    chk("hz_tag1", iss_tag, 8'h15);
    tick();
    chk("hz_tag2", iss_tag, 8'h16);
    tick();
    iss_ready = 1'b0;
    chk("hz_empty", empty, 1);

    // x0 destination and immediate rs2
    push(8'h21, 1, 0, 4'd0, 4'd0, 4'd0);
    push(8'h22, 1, 1, 4'd3, 4'd0, 4'd5);
    push(8'h23, 1, 0, 4'd5, 4'd4, 4'd6);
    chk("x0_count", count, 3);
    chk("x0_tag0", iss_tag, 8'h21);
    iss_ready = 1'b1;
    tick();
    chk("x0_tag1", iss_tag, 8'h22);
    tick();
    chk("x0_tag2", iss_tag, 8'h23);
    chk("x0_count1", count, 1);
    tick();
    iss_ready = 1'b0;
    chk("x0_empty", empty, 1);

    // Fill to full
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i), 1, 0, 4'(i + 1), 4'd0, 4'd0);
    chk("full_count", count, 8);
    chk("full_flag", full, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_tag", iss_tag, 8'h30);
    // Issue while full with a push offered: push must be refused
    in_valid = 1'b1; in_tag = 8'h40; in_rd = 4'd9; iss_ready = 1'b1;
    #1;
    chk("full_in_ready_iss", in_ready, 0);
    tick();
    in_valid = 1'b0; iss_ready = 1'b0;
    chk("full_count7", count, 7);
    chk("full_in_ready7", in_ready, 1);
    chk("full_flag7", full, 0);
    chk("full_tag31", iss_tag, 8'h31);
    // Simultaneous push and issue
    in_valid = 1'b1; in_tag = 8'h41; in_rd = 4'd10; in_rs1 = 4'd0; in_rs2 = 4'd0;
    iss_ready = 1'b1;
    tick();
    in_valid = 1'b0; iss_ready = 1'b0;
    chk("sim_count", count, 7);
    exp_tags = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h41};
    iss_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("drain_tag%0d", i), iss_tag, exp_tags[i]);
      tick();
    end
    iss_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);

    // Flush with push and issue offered
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i), 1, 0, 4'(i + 1), 4'd0, 4'd0);
    chk("fl_count5", count, 5);
    flush = 1'b1; in_valid = 1'b1; in_tag = 8'h5F; iss_ready = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    chk("fl_iss_valid", iss_valid, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_iss_valid_after", iss_valid, 0);

    // Mid-run reset with push and issue offered
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1, 0, 4'(i + 1), 4'd0, 4'd0);
    chk("mr_count5", count, 5);
    rst = 1'b0; in_valid = 1'b1; in_tag = 8'h6F; iss_ready = 1'b1;
    #1;
    chk("mr_in_ready", in_ready, 0);
    chk("mr_iss_valid", iss_valid, 0);
    tick();
    rst = 1'b1; in_valid = 1'b0; iss_ready = 1'b0;
    #1;
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_in_ready_after", in_ready, 1);
    push(8'h70, 1, 0, 4'd2, 4'd3, 4'd4);
    chk("mr_count1", count, 1);
    chk("mr_tag", iss_tag, 8'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
